// File: rtl/inert_sensor_resp.sv
// SPI mode-0 responder standing in for the inertial sensor: 16-bit register frames,
// periodic pitch sampling with a data-ready interrupt cleared by reading PITCH_H.
module inert_sensor_resp #(
    parameter int          INT_PERIOD   = 4096,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic [15:0] ptch_in,
    output logic        MISO,
    output logic        INT
);
    localparam int             CW       = $clog2(INT_PERIOD);
    localparam logic [CW-1:0]  CNT_LAST = CW'(INT_PERIOD - 1);

    localparam logic [6:0] ADDR_INT_CFG  = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
    localparam logic [6:0] ADDR_CTRL     = 7'h10;
    localparam logic [6:0] ADDR_PITCH_L  = 7'h22;
    localparam logic [6:0] ADDR_PITCH_H  = 7'h23;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic            ss_s1, ss_s2, ss_s3;
    logic            sclk_s1, sclk_s2, sclk_s3;
    logic            mosi_s1, mosi_s2;
    logic [15:0]     rx;
    logic [4:0]      bit_cnt;
    logic [7:0]      tx;
    logic            rd_phase;
    logic [7:0]      int_cfg;
    logic [7:0]      ctrl;
    logic [15:0]     pitch_shadow;
    logic [CW-1:0]   smp_cnt;
    logic            drdy;
    logic            int_q;

    logic            ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [15:0]     rx_shift;
    logic [7:0]      rd_byte;
    logic            frame_done, wr_en, rd_clr, sample;

    assign ss_fall   = ~ss_s2 & ss_s3;
    assign ss_rise   = ss_s2 & ~ss_s3;
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign rx_shift  = {rx[14:0], mosi_s2};

    assign frame_done = (state == SHIFT) && ss_rise && (bit_cnt == 5'd16);
    assign wr_en      = frame_done && !rx[15];
    assign rd_clr     = frame_done && rx[15] && (rx[14:8] == ADDR_PITCH_H);
    assign sample     = (ctrl != 8'h00) && (smp_cnt == CNT_LAST);

    // Read data is looked up from the command byte as it completes on the 8th rise.
    always_comb begin
        rd_byte = 8'h00;
        case (rx_shift[6:0])
            ADDR_INT_CFG:  rd_byte = int_cfg;
            ADDR_WHO_AM_I: rd_byte = WHO_AM_I_VAL;
            ADDR_CTRL:     rd_byte = ctrl;
            ADDR_PITCH_L:  rd_byte = pitch_shadow[7:0];
            ADDR_PITCH_H:  rd_byte = pitch_shadow[15:8];
            default:       rd_byte = 8'h00;
        endcase
    end

    // SS_n chain resets low so a select already active at reset release never looks like a fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_s1   <= 1'b0;
            ss_s2   <= 1'b0;
            ss_s3   <= 1'b0;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ss_s1   <= SS_n;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rx       <= 16'h0000;
            bit_cnt  <= 5'd0;
            tx       <= 8'h00;
            rd_phase <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt  <= 5'd0;
                    rd_phase <= 1'b0;
                    if (ss_fall) begin
                        state <= SHIFT;
                        rx    <= 16'h0000;
                        tx    <= 8'h00;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= 5'd0;
                        rd_phase <= 1'b0;
                    end else if (sclk_rise && bit_cnt != 5'd16) begin
                        rx      <= rx_shift;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7 && rx_shift[7]) begin
                            tx       <= rd_byte;
                            rd_phase <= 1'b1;
                        end
                    end else if (sclk_fall && rd_phase && bit_cnt >= 5'd9 && bit_cnt <= 5'd15) begin
                        tx <= {tx[6:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_cfg      <= 8'h00;
            ctrl         <= 8'h00;
            pitch_shadow <= 16'h0000;
            smp_cnt      <= '0;
            drdy         <= 1'b0;
            int_q        <= 1'b0;
        end else begin
            if (wr_en && rx[14:8] == ADDR_INT_CFG) int_cfg <= rx[7:0];
            if (wr_en && rx[14:8] == ADDR_CTRL)    ctrl    <= rx[7:0];

            if (ctrl == 8'h00 || sample)
                smp_cnt <= '0;
            else
                smp_cnt <= smp_cnt + 1'b1;
            // Turning sampling off restarts the period from zero immediately.
            if (wr_en && rx[14:8] == ADDR_CTRL && rx[7:0] == 8'h00)
                smp_cnt <= '0;

            if (sample) pitch_shadow <= ptch_in;

            if (sample)      drdy <= 1'b1;
            else if (rd_clr) drdy <= 1'b0;

            int_q <= drdy & int_cfg[0];
        end
    end

    assign MISO = rd_phase & tx[7];
    assign INT  = int_q;

endmodule
